dma_controller: RTL and testbench

//  External-device DMA engine that shares the CPU data-memory bus.
//  - Device interrupt raises dma_begin to the CPU; the CPU answers with cmd (start, address, length).
//  - Requests the bus with BR and waits for BG.
//  - Writes device bursts (FETCH_SIZE bits per memory write) into data memory.
//  - Releases the bus and pulses dma_end, after which the CPU resumes its caches.
//  - Sits beside cpu at top level; its d_* outputs drive the shared bus only while oe=1.

---
 rtl/dma_pkg.sv | 18 +
 rtl/dma_addr_gen.sv | 69 ++++++
 rtl/dma_controller.sv | 115 +++++++++++
 tb/tb_dma_controller.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared DMA engine parameters and FSM state encoding.
package dma_pkg;
    localparam int WORD_SIZE   = 16;
    localparam int FETCH_SIZE  = 64;
    localparam int BURST_WORDS = FETCH_SIZE / WORD_SIZE;
    localparam int MAX_BURSTS  = 15;
    localparam int MEM_LATENCY = 4;
    localparam int LEN_W       = 4;
    localparam int LC_W        = $clog2(MEM_LATENCY);

    typedef enum logic [2:0] {
        DMA_IDLE = 3'd0,
        DMA_REQ  = 3'd1,
        DMA_XFER = 3'd2,
        DMA_REL  = 3'd3,
        DMA_FIN  = 3'd4
    } dma_state_e;
endpackage

// File: rtl/dma_addr_gen.sv
// Burst bookkeeping: latched base/length, burst index, latency counter and
// the registered destination address base + BURST_WORDS*i.
module dma_addr_gen
    import dma_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic                 lc_clr_i,
    input  logic                 lc_inc_i,
    input  logic                 i_inc_i,
    input  logic [WORD_SIZE-1:0] base_i,
    input  logic [LEN_W-1:0]     len_i,
    output logic [LEN_W-1:0]     idx_o,
    output logic                 last_beat_o,
    output logic                 last_burst_o,
    output logic [WORD_SIZE-1:0] addr_o
);
    logic [WORD_SIZE-1:0] base_q, base_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     i_q, i_d;
    logic [LC_W-1:0]      lc_q, lc_d;

    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        i_d    = i_q;
        lc_d   = lc_q;
        if (load_i) begin
            base_d = base_i;
            len_d  = len_i;
            i_d    = '0;
            lc_d   = '0;
        end else begin
            if (lc_clr_i) begin
                lc_d = '0;
            end else if (lc_inc_i) begin
                lc_d = lc_q + LC_W'(1);
            end
            if (i_inc_i) begin
                i_d = i_q + LEN_W'(1);
            end
        end
        // Address wraps silently modulo 2^WORD_SIZE.
        addr_d = base_d + WORD_SIZE'(BURST_WORDS * int'(i_d));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            base_q <= '0;
            len_q  <= '0;
            i_q    <= '0;
            lc_q   <= '0;
            addr_q <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            i_q    <= i_d;
            lc_q   <= lc_d;
            addr_q <= addr_d;
        end
    end

    assign idx_o        = i_q;
    assign addr_o       = addr_q;
    assign last_beat_o  = (lc_q == LC_W'(MEM_LATENCY - 1));
    assign last_burst_o = (i_q == len_q - LEN_W'(1));
endmodule

// File: rtl/dma_controller.sv
// Device-to-memory DMA engine on the shared CPU data bus: command handshake,
// BR/BG bus arbitration, burst writes and a completion pulse.
module dma_controller
    import dma_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  dev_intr,
    output logic                  dma_begin,
    input  logic                  cmd,
    input  logic [WORD_SIZE-1:0]  cmd_addr,
    input  logic [3:0]            cmd_len,
    output logic                  BR,
    input  logic                  BG,
    output logic                  oe,
    output logic                  d_writeM,
    output logic [WORD_SIZE-1:0]  d_address,
    output logic [FETCH_SIZE-1:0] d_data,
    output logic [3:0]            dev_index,
    input  logic [FETCH_SIZE-1:0] dev_data,
    output logic                  dma_end
);
    dma_state_e state_q, state_d;
    logic       stall_q, stall_d;
    logic       br_q, we_q, begin_q, end_q;
    logic       load, lc_clr, lc_inc, i_inc;
    logic       last_beat, last_burst;

    dma_addr_gen u_addr_gen (
        .clk_i        (Clk),
        .rst_n_i      (Reset_N),
        .load_i       (load),
        .lc_clr_i     (lc_clr),
        .lc_inc_i     (lc_inc),
        .i_inc_i      (i_inc),
        .base_i       (cmd_addr),
        .len_i        (cmd_len),
        .idx_o        (dev_index),
        .last_beat_o  (last_beat),
        .last_burst_o (last_burst),
        .addr_o       (d_address)
    );

    always_comb begin
        state_d = state_q;
        stall_d = 1'b0;
        load    = 1'b0;
        lc_clr  = 1'b0;
        lc_inc  = 1'b0;
        i_inc   = 1'b0;
        case (state_q)
            DMA_IDLE: begin
                if (cmd) begin
                    load    = 1'b1;
                    state_d = (cmd_len == 4'd0) ? DMA_FIN : DMA_REQ;
                end
            end
            DMA_REQ: begin
                if (BG) begin
                    state_d = DMA_XFER;
                    lc_clr  = 1'b1;
                end
            end
            DMA_XFER: begin
                // A lost grant freezes i/lc; the interrupted burst reruns from lc=0.
                if (!BG) begin
                    stall_d = 1'b1;
                end else if (stall_q) begin
                    lc_clr = 1'b1;
                end else if (last_beat) begin
                    if (last_burst) begin
                        state_d = DMA_REL;
                    end else begin
                        i_inc  = 1'b1;
                        lc_clr = 1'b1;
                    end
                end else begin
                    lc_inc = 1'b1;
                end
            end
            DMA_REL: begin
                if (!BG) begin
                    state_d = DMA_FIN;
                end
            end
            DMA_FIN:  state_d = DMA_IDLE;
            default:  state_d = DMA_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q <= DMA_IDLE;
            stall_q <= 1'b0;
            br_q    <= 1'b0;
            we_q    <= 1'b0;
            begin_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            br_q    <= (state_d == DMA_REQ) || (state_d == DMA_XFER);
            we_q    <= (state_d == DMA_XFER) && !stall_d;
            begin_q <= (state_d == DMA_IDLE) && dev_intr;
            end_q   <= (state_q == DMA_FIN);
        end
    end

    assign BR        = br_q;
    assign oe        = we_q;
    assign d_writeM  = we_q;
    assign dma_begin = begin_q;
    assign dma_end   = end_q;
    assign d_data    = (state_q == DMA_XFER) ? dev_data : '0;
endmodule

// File: tb/tb_dma_controller.sv
// Scenario bench for dma_controller: expected bursts are queued as commands are
// issued and matched against write runs collected from the bus.
module tb_dma_controller;
    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    logic        dev_intr = 1'b0;
    logic        cmd = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic        BG = 1'b0;
    logic [63:0] dev_data;
    logic        dma_begin, BR, oe, d_writeM, dma_end;
    logic [15:0] d_address;
    logic [63:0] d_data;
    logic [3:0]  dev_index;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
        int          beats;
    } run_t;
    run_t exp_q[$];
    run_t obs_q[$];

    logic [15:0] run_addr = '0;
    logic [63:0] run_data = '0;
    int          run_len = 0;

    dma_controller dut (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .dev_intr  (dev_intr),
        .dma_begin (dma_begin),
        .cmd       (cmd),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .BR        (BR),
        .BG        (BG),
        .oe        (oe),
        .d_writeM  (d_writeM),
        .d_address (d_address),
        .d_data    (d_data),
        .dev_index (dev_index),
        .dev_data  (dev_data),
        .dma_end   (dma_end)
    );

    always #5 Clk = ~Clk;

    function automatic logic [63:0] pat(input logic [3:0] idx);
        return {12'hAB1, idx, 16'hC0DE, 12'h5E7, idx, 16'h0F0F};
    endfunction

    always_comb dev_data = pat(dev_index);

    // Collect each contiguous write run (same address) as one observed burst.
    always @(negedge Clk) begin
        if (d_writeM && (run_len == 0 || d_address != run_addr)) begin
            if (run_len != 0) obs_q.push_back('{addr: run_addr, data: run_data, beats: run_len});
            run_addr <= d_address;
            run_data <= d_data;
            run_len  <= 1;
        end else if (d_writeM) begin
            run_len <= run_len + 1;
        end else if (run_len != 0) begin
            obs_q.push_back('{addr: run_addr, data: run_data, beats: run_len});
            run_len <= 0;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] addr, input logic [3:0] idx, input int beats);
        exp_q.push_back('{addr: addr, data: pat(idx), beats: beats});
    endtask

    task automatic run_xfer(input logic [15:0] addr, input logic [3:0] len, input int grant_delay,
                            input int glitch_at, input bit poke, output logic br_up,
                            output int wait_wr, output int br_cycles, output int end_pulses);
        cmd = 1'b1; cmd_addr = addr; cmd_len = len;
        tick();
        cmd = 1'b0; cmd_addr = '0; cmd_len = '0;
        br_up = BR;
        wait_wr = 0;
        for (int k = 0; k < grant_delay; k++) begin
            if (d_writeM) wait_wr++;
            tick();
        end
        if (d_writeM) wait_wr++;
        BG = 1'b1;
        br_cycles = -1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (!BR) begin
                br_cycles = c;
                break;
            end
            if (c == glitch_at) BG = 1'b0;
            if (glitch_at > 0 && c == glitch_at + 2) BG = 1'b1;
            if (poke && c == 3) begin
                cmd = 1'b1; cmd_addr = 16'h5555; cmd_len = 4'd7;
            end
            if (poke && c == 4) begin
                cmd = 1'b0; cmd_addr = '0; cmd_len = '0;
            end
        end
        BG = 1'b0;
        end_pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (dma_end) end_pulses++;
        end
    endtask

    task automatic test_reset();
        Reset_N = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({BR, oe, d_writeM, dma_begin, dma_end} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: BR/oe/we/begin/end=%b required 00000", {BR, oe, d_writeM, dma_begin, dma_end});
        end
        n_cmp++;
        if (d_address !== 16'h0 || dev_index !== 4'h0 || d_data !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_bus: addr=%h idx=%h data=%h required all zero", d_address, dev_index, d_data);
        end
        Reset_N = 1'b1;
        tick();
        $display("reset done");
    endtask

    task automatic test_basic();
        logic br_up;
        int   wr, brc, ends;
        run_t e, o;
        dev_intr = 1'b1;
        tick();
        n_cmp++;
        if (dma_begin !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_begin: dma_begin=%b required 1", dma_begin);
        end
        push_exp(16'h01F4, 4'd0, 4);
        push_exp(16'h01F8, 4'd1, 4);
        push_exp(16'h01FC, 4'd2, 4);
        run_xfer(16'h01F4, 4'd3, 0, 0, 1'b0, br_up, wr, brc, ends);
        n_cmp++;
        if (br_up !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_br: BR after cmd=%b required 1", br_up);
        end
        n_cmp++;
        if (brc != 13) begin
            n_bad++;
            $display("FAIL basic_latency: BR low after %0d cycles required 13", brc);
        end
        n_cmp++;
        if (ends != 1) begin
            n_bad++;
            $display("FAIL basic_end: dma_end high %0d cycles required 1", ends);
        end
        n_cmp++;
        if (dma_begin !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_begin_idle: dma_begin=%b required 1", dma_begin);
        end
        dev_intr = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL basic_burst: no burst seen, required addr %h beats %0d", e.addr, e.beats);
            end else begin
                o = obs_q.pop_front();
                $display("basic burst addr=%h beats=%0d data=%h", o.addr, o.beats, o.data);
                if (o.addr !== e.addr || o.data !== e.data || o.beats != e.beats) begin
                    n_bad++;
                    $display("FAIL basic_burst: got %h/%h/%0d required %h/%h/%0d", o.addr, o.data, o.beats, e.addr, e.data, e.beats);
                end
            end
        end
    endtask

    task automatic test_delayed_grant();
        logic br_up;
        int   wr, brc, ends;
        run_t e, o;
        push_exp(16'h2000, 4'd0, 4);
        push_exp(16'h2004, 4'd1, 4);
        push_exp(16'h2008, 4'd2, 4);
        run_xfer(16'h2000, 4'd3, 10, 0, 1'b0, br_up, wr, brc, ends);
        n_cmp++;
        if (wr != 0) begin
            n_bad++;
            $display("FAIL delay_nowrite: %0d write cycles before grant required 0", wr);
        end
        n_cmp++;
        if (brc != 13 || ends != 1) begin
            n_bad++;
            $display("FAIL delay_done: BR low after %0d ends %0d required 13 and 1", brc, ends);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL delay_burst: no burst seen, required addr %h beats %0d", e.addr, e.beats);
            end else begin
                o = obs_q.pop_front();
                $display("delay burst addr=%h beats=%0d", o.addr, o.beats);
                if (o.addr !== e.addr || o.data !== e.data || o.beats != e.beats) begin
                    n_bad++;
                    $display("FAIL delay_burst: got %h/%h/%0d required %h/%h/%0d", o.addr, o.data, o.beats, e.addr, e.data, e.beats);
                end
            end
        end
    endtask

    task automatic test_zero_length();
        int first_end = -1;
        int ends = 0;
        int br_seen = 0;
        cmd = 1'b1; cmd_addr = 16'h1234; cmd_len = 4'd0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            cmd = 1'b0;
            if (BR) br_seen++;
            if (dma_end) begin
                ends++;
                if (first_end < 0) first_end = k;
            end
        end
        $display("zero-length: dma_end at cycle %0d", first_end);
        n_cmp++;
        if (first_end != 2 || ends != 1) begin
            n_bad++;
            $display("FAIL zero_end: first at %0d count %0d required 2 and 1", first_end, ends);
        end
        n_cmp++;
        if (br_seen != 0 || obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL zero_bus: BR cycles %0d bursts %0d required 0 and 0", br_seen, obs_q.size());
        end
    endtask

    task automatic test_reset_mid_op();
        int   ends = 0;
        int   br_seen = 0;
        run_t e, o;
        dev_intr = 1'b1;
        push_exp(16'h0400, 4'd0, 4);
        push_exp(16'h0404, 4'd1, 3);
        cmd = 1'b1; cmd_addr = 16'h0400; cmd_len = 4'd3;
        tick();
        cmd = 1'b0;
        BG = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        n_cmp++;
        if (dma_begin !== 1'b0 || dev_index !== 4'd1) begin
            n_bad++;
            $display("FAIL midop_xfer: begin=%b idx=%0d required 0 and 1", dma_begin, dev_index);
        end
        Reset_N = 1'b0;
        tick();
        n_cmp++;
        if ({BR, d_writeM, oe} !== 3'b000 || dev_index !== 4'd0) begin
            n_bad++;
            $display("FAIL midop_reset: BR/we/oe=%b idx=%0d required 000 and 0", {BR, d_writeM, oe}, dev_index);
        end
        Reset_N = 1'b1;
        BG = 1'b0;
        dev_intr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (dma_end) ends++;
            if (BR) br_seen++;
        end
        n_cmp++;
        if (ends != 0 || br_seen != 0) begin
            n_bad++;
            $display("FAIL midop_after: dma_end %0d BR %0d required 0 and 0", ends, br_seen);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL midop_burst: no burst seen, required addr %h beats %0d", e.addr, e.beats);
            end else begin
                o = obs_q.pop_front();
                $display("midop burst addr=%h beats=%0d", o.addr, o.beats);
                if (o.addr !== e.addr || o.data !== e.data || o.beats != e.beats) begin
                    n_bad++;
                    $display("FAIL midop_burst: got %h/%h/%0d required %h/%h/%0d", o.addr, o.data, o.beats, e.addr, e.data, e.beats);
                end
            end
        end
    endtask

    task automatic test_grant_glitch();
        logic br_up;
        int   wr, brc, ends;
        run_t e, o;
        push_exp(16'h3000, 4'd0, 2);
        push_exp(16'h3000, 4'd0, 4);
        push_exp(16'h3004, 4'd1, 4);
        run_xfer(16'h3000, 4'd2, 0, 2, 1'b0, br_up, wr, brc, ends);
        n_cmp++;
        if (brc != 13 || ends != 1) begin
            n_bad++;
            $display("FAIL glitch_done: BR low after %0d ends %0d required 13 and 1", brc, ends);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL glitch_burst: no burst seen, required addr %h beats %0d", e.addr, e.beats);
            end else begin
                o = obs_q.pop_front();
                $display("glitch burst addr=%h beats=%0d", o.addr, o.beats);
                if (o.addr !== e.addr || o.data !== e.data || o.beats != e.beats) begin
                    n_bad++;
                    $display("FAIL glitch_burst: got %h/%h/%0d required %h/%h/%0d", o.addr, o.data, o.beats, e.addr, e.data, e.beats);
                end
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic br_up;
        int   wr, brc, ends;
        int   br_seen = 0;
        run_t e, o;
        push_exp(16'hFFFC, 4'd0, 4);
        push_exp(16'h0000, 4'd1, 4);
        run_xfer(16'hFFFC, 4'd2, 0, 0, 1'b1, br_up, wr, brc, ends);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (BR) br_seen++;
        end
        n_cmp++;
        if (brc != 9 || ends != 1 || br_seen != 0) begin
            n_bad++;
            $display("FAIL wrap_done: BR low after %0d ends %0d late BR %0d required 9, 1, 0", brc, ends, br_seen);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL wrap_burst: no burst seen, required addr %h beats %0d", e.addr, e.beats);
            end else begin
                o = obs_q.pop_front();
                $display("wrap burst addr=%h beats=%0d", o.addr, o.beats);
                if (o.addr !== e.addr || o.data !== e.data || o.beats != e.beats) begin
                    n_bad++;
                    $display("FAIL wrap_burst: got %h/%h/%0d required %h/%h/%0d", o.addr, o.data, o.beats, e.addr, e.data, e.beats);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL wrap_extra: %0d unexpected bursts required 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delayed_grant();
        test_zero_length();
        test_reset_mid_op();
        test_grant_glitch();
        test_addr_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
